tmp_seq_ctrl: RTL

Parametrised successor to the temperature-sensor switch sequencer. It generates non-overlapping diode/big-diode phase clocks and precharge, and drives comparator-steered source/sink charge pulses. It also runs an incremental delta-sigma conversion: settling periods first, then `OSR` counted periods, ending with a registered result and a one-cycle `valid`. It sits between the analog sensor front-end and the digital readout, and supports single-shot and continuous modes.

---
 rtl/tmp_seq_ctrl.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/tmp_seq_ctrl.sv
// ----------------------------------------------------------------------------
// tmp_seq_ctrl
//
// Switch sequencer for the temperature sensor front-end. It produces the
// precharge pulse and the non-overlapping small-diode (PII1/PII2) and
// big-diode (PI1/PI2) phase switches. During the big-diode phase it steers
// the charge source/sink from the comparator. It also runs an incremental
// delta-sigma conversion: SETUP_PERIODS uncounted settling periods, then OSR
// counted periods. At the end the count of cmp=1 decisions is registered and
// flagged with a one-cycle valid pulse.
//
// One period is BLANK_D (1) + DIODE (DIODE_CYC) + BLANK_B (1) + BIGDIODE
// (BIG_CYC) cycles. Every BIGDIODE cycle is one comparator decision.
//
// Parameters
//   DIODE_CYC      cycles the small-diode phase is held (>= 1)
//   BIG_CYC        cycles the big-diode phase is held, i.e. decisions per
//                  period (>= 1)
//   SETUP_PERIODS  uncounted settling periods per conversion (>= 0)
//   OSR            counted periods per conversion (>= 1)
//   RES_W          result width, wide enough for OSR*BIG_CYC
//
// Ports
//   clk         system clock, rising edge
//   reset       synchronous reset, active low
//   start       single-shot request, only looked at in IDLE
//   continuous  back-to-back conversions, looked at in IDLE and DONE
//   cmp         comparator output, sampled at the end of each BIGDIODE cycle
//   preChrg     precharge switch
//   PII1, PII2  small-diode phase switches
//   PI1, PI2    big-diode phase switches
//   src_n       current source enable, active low
//   snk         current sink enable
//   busy        conversion in progress (PRECHARGE through DONE)
//   result      cmp=1 decisions counted in the last conversion
//   valid       one-cycle pulse when result updates
// ----------------------------------------------------------------------------
module tmp_seq_ctrl #(
   parameter int DIODE_CYC     = 1,
   parameter int BIG_CYC       = 3,
   parameter int SETUP_PERIODS = 30,
   parameter int OSR           = 256,
   localparam int RES_W        = $clog2(OSR*BIG_CYC+1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             continuous,
   input  logic             cmp,
   output logic             preChrg,
   output logic             PII1,
   output logic             PII2,
   output logic             PI1,
   output logic             PI2,
   output logic             src_n,
   output logic             snk,
   output logic             busy,
   output logic [RES_W-1:0] result,
   output logic             valid
);

   // Period index runs 0 .. SETUP_PERIODS+OSR-1 within one conversion.
   localparam int TOTAL_PERIODS = SETUP_PERIODS + OSR;
   localparam int PER_W         = $clog2(TOTAL_PERIODS + 1);

   // The phase counter times whichever of the two held phases is longer.
   localparam int PH_MAX = (DIODE_CYC > BIG_CYC) ? DIODE_CYC : BIG_CYC;
   localparam int PH_W   = $clog2(PH_MAX + 1);

   localparam logic [PER_W-1:0] LAST_PERIOD = PER_W'(TOTAL_PERIODS - 1);
   localparam logic [PER_W-1:0] FIRST_COUNTED = PER_W'(SETUP_PERIODS);
   localparam logic [PH_W-1:0]  DIODE_LAST = PH_W'(DIODE_CYC - 1);
   localparam logic [PH_W-1:0]  BIG_LAST   = PH_W'(BIG_CYC - 1);

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_PRECHARGE = 3'd1;
   localparam logic [2:0] S_BLANK_D   = 3'd2;
   localparam logic [2:0] S_DIODE     = 3'd3;
   localparam logic [2:0] S_BLANK_B   = 3'd4;
   localparam logic [2:0] S_BIGDIODE  = 3'd5;
   localparam logic [2:0] S_DONE      = 3'd6;

   logic [2:0]       state;
   logic [2:0]       state_nxt;
   logic [PH_W-1:0]  phase_cnt;
   logic [PH_W-1:0]  phase_nxt;
   logic [PER_W-1:0] period_cnt;
   logic [PER_W-1:0] period_nxt;
   logic [RES_W-1:0] acc;
   logic [RES_W-1:0] acc_nxt;
   logic             count_en;
   logic             phase_end;

   // A decision is counted only once the settling periods are over. The
   // accumulator can never exceed OSR*BIG_CYC, so no saturation is needed.
   always_comb begin
      count_en = (state == S_BIGDIODE) && cmp && (period_cnt >= FIRST_COUNTED);
   end

   // End of the currently held phase, valid in DIODE and BIGDIODE only.
   always_comb begin
      phase_end = 1'b0;
      if (state == S_DIODE) begin
         phase_end = (phase_cnt == DIODE_LAST);
      end else if (state == S_BIGDIODE) begin
         phase_end = (phase_cnt == BIG_LAST);
      end
   end

   // Next-state and counter logic. PRECHARGE wipes every counter so that
   // each conversion starts clean, whether entered from IDLE or from DONE.
   always_comb begin
      state_nxt  = state;
      phase_nxt  = phase_cnt;
      period_nxt = period_cnt;
      acc_nxt    = acc;

      if (count_en) begin
         acc_nxt = acc + RES_W'(1);
      end

      case (state)
         S_IDLE: begin
            if (start || continuous) begin
               state_nxt = S_PRECHARGE;
            end
         end

         S_PRECHARGE: begin
            state_nxt  = S_BLANK_D;
            phase_nxt  = '0;
            period_nxt = '0;
            acc_nxt    = '0;
         end

         S_BLANK_D: begin
            state_nxt = S_DIODE;
            phase_nxt = '0;
         end

         S_DIODE: begin
            if (phase_end) begin
               state_nxt = S_BLANK_B;
               phase_nxt = '0;
            end else begin
               phase_nxt = phase_cnt + PH_W'(1);
            end
         end

         S_BLANK_B: begin
            state_nxt = S_BIGDIODE;
            phase_nxt = '0;
         end

         S_BIGDIODE: begin
            if (phase_end) begin
               phase_nxt = '0;
               if (period_cnt == LAST_PERIOD) begin
                  state_nxt = S_DONE;
               end else begin
                  state_nxt  = S_BLANK_D;
                  period_nxt = period_cnt + PER_W'(1);
               end
            end else begin
               phase_nxt = phase_cnt + PH_W'(1);
            end
         end

         S_DONE: begin
            state_nxt = continuous ? S_PRECHARGE : S_IDLE;
         end

         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // State and counter registers.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state      <= S_IDLE;
         phase_cnt  <= '0;
         period_cnt <= '0;
         acc        <= '0;
      end else begin
         state      <= state_nxt;
         phase_cnt  <= phase_cnt == phase_cnt ? phase_nxt : phase_nxt;
         period_cnt <= period_nxt;
         acc        <= acc_nxt;
      end
   end

   // Phase switches, busy and valid are decoded from the next state so that
   // the registered outputs line up with the state register in each cycle.
   // The blank states guarantee PI* and PII* are never high together.
   always_ff @(posedge clk) begin
      if (!reset) begin
         preChrg <= 1'b0;
         PII1    <= 1'b0;
         PII2    <= 1'b0;
         PI1     <= 1'b0;
         PI2     <= 1'b0;
         busy    <= 1'b0;
         valid   <= 1'b0;
      end else begin
         preChrg <= (state_nxt == S_PRECHARGE);
         PII1    <= (state_nxt == S_BLANK_D) || (state_nxt == S_DIODE);
         PII2    <= (state_nxt == S_DIODE);
         PI1     <= (state_nxt == S_BLANK_B) || (state_nxt == S_BIGDIODE);
         PI2     <= (state_nxt == S_BIGDIODE);
         busy    <= (state_nxt != S_IDLE);
         valid   <= (state_nxt == S_DONE);
      end
   end

   // Charge pulses follow their decision by one cycle: they are registered
   // from the current state and cmp, not from the next state. After the last
   // BIGDIODE cycle of a period the pulse lands in BLANK_D or DONE.
   always_ff @(posedge clk) begin
      if (!reset) begin
         src_n <= 1'b1;
         snk   <= 1'b0;
      end else begin
         src_n <= !((state == S_BIGDIODE) && cmp);
         snk   <= (state == S_BIGDIODE) && !cmp;
      end
   end

   // The result is loaded on the edge that enters DONE. acc_nxt already
   // includes the final decision taken on that same edge.
   always_ff @(posedge clk) begin
      if (!reset) begin
         result <= '0;
      end else if (state_nxt == S_DONE) begin
         result <= acc_nxt;
      end
   end

endmodule
